// File: rtl/imem_arbiter.sv
// Two-port arbiter/sequencer for a single-port synchronous-read instruction memory.
// Define IMEM_ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed fetch priority.
module imem_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      f_valid,
    output logic                      f_ready,
    input  logic [ADDRESS_WIDTH-1:0]  f_addr,
    output logic                      f_rsp_valid,
    output logic [DATA_WIDTH-1:0]     f_rsp_data,
    input  logic                      l_valid,
    output logic                      l_ready,
    input  logic                      l_we,
    input  logic [ADDRESS_WIDTH-1:0]  l_addr,
    input  logic [DATA_WIDTH-1:0]     l_wdata,
    input  logic [DATA_WIDTH/8-1:0]   l_be,
    output logic                      l_rsp_valid,
    output logic [DATA_WIDTH-1:0]     l_rsp_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   owner_l;
    logic   req_we;
    logic   grant_f;
    logic   grant_l;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic last_l;

    // Under contention the port that did not win last time gets the slot.
    always_comb begin
        grant_f = f_valid && (!l_valid || last_l);
        grant_l = l_valid && !grant_f;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_l <= 1'b1;
        else if (state == IDLE && (grant_f || grant_l))
            last_l <= grant_l;
    end
`else
    always_comb begin
        grant_f = f_valid;
        grant_l = l_valid && !f_valid;
    end
`endif

    assign f_ready = rst_n && (state == IDLE) && grant_f;
    assign l_ready = rst_n && (state == IDLE) && grant_l;

    // The mem_* registers double as the captured request: loaded at handshake, cleared after ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_l     <= 1'b0;
            req_we      <= 1'b0;
            f_rsp_valid <= 1'b0;
            f_rsp_data  <= '0;
            l_rsp_valid <= 1'b0;
            l_rsp_data  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_f || grant_l) begin
                        owner_l   <= grant_l;
                        req_we    <= grant_l && l_we;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_l && l_we;
                        mem_addr  <= grant_l ? l_addr : f_addr;
                        mem_wdata <= grant_l ? l_wdata : '0;
                        mem_be    <= grant_l ? l_be : '1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_be    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (owner_l) begin
                        l_rsp_data  <= req_we ? '0 : mem_rdata;
                        l_rsp_valid <= 1'b1;
                    end else begin
                        f_rsp_data  <= mem_rdata;
                        f_rsp_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    f_rsp_valid <= 1'b0;
                    l_rsp_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter: byte-array memory model, transaction-level reference
// model checked every cycle, plus directed reset / write / contention scenarios.
module tb_imem_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int BW = DW / 8;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_valid = 1'b0, f_ready, f_rsp_valid;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_rsp_data;
    logic          l_valid = 1'b0, l_ready, l_we = 1'b0, l_rsp_valid;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0, l_rsp_data;
    logic [BW-1:0] l_be = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    imem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_be(l_be), .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] w;
        w = 32'h00500093;
        if (i >= 4 && i < 8) return w[8*(i-4) +: 8];
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // Memory the DUT actually talks to
    logic [7:0] sim_mem [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) sim_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we)
                for (int i = 0; i < BW; i++) mem_rdata[8*i +: 8] <= sim_mem[16'(mem_addr + 16'(i))];
            if (mem_en && mem_we)
                for (int i = 0; i < BW; i++)
                    if (mem_be[i]) sim_mem[16'(mem_addr + 16'(i))] = mem_wdata[8*i +: 8];
        end
    end

    // Reference model: transaction level, each access occupies 4 cycles after its grant
    logic [7:0]    ref_mem [0:65535];
    int            phase = 0;
    bit            m_owner_l, m_we, m_last_l = 1'b1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] exp_fd = '0, exp_ld = '0;
    int            f_pulses = 0, l_pulses = 0, both_cnt = 0;
    bit            f_acc = 1'b0, l_acc = 1'b0;
    bit            grant_q[$];
    bit            mon_en = 1'b0;

    initial begin
        bit fwin, lwin;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (mon_en) begin
                fwin = f_valid && (!l_valid || !RR || m_last_l);
                lwin = l_valid && !fwin;
                check("f_ready", f_ready, rst_n && phase == 0 && fwin);
                check("l_ready", l_ready, rst_n && phase == 0 && lwin);
                if (phase == 1) begin
                    check("mem_req", {mem_en, mem_we, mem_addr, mem_be},
                          {1'b1, m_we, m_addr, (m_owner_l ? m_be : 4'hF)});
                    if (m_we) check("mem_wdata", mem_wdata, m_wdata);
                end else begin
                    check("mem_idle", {mem_en, mem_we, mem_addr, mem_wdata, mem_be}, 64'd0);
                end
                check("f_rsp_valid", f_rsp_valid, phase == 3 && !m_owner_l);
                check("l_rsp_valid", l_rsp_valid, phase == 3 && m_owner_l);
                check("f_rsp_data", f_rsp_data, exp_fd);
                check("l_rsp_data", l_rsp_data, exp_ld);
                if (f_rsp_valid) f_pulses++;
                if (l_rsp_valid) l_pulses++;
                if (f_ready && l_ready) both_cnt++;
                f_acc = f_valid && f_ready;
                l_acc = l_valid && l_ready;
                if (f_acc) grant_q.push_back(1'b0);
                if (l_acc) grant_q.push_back(1'b1);

                if (!rst_n) begin
                    phase = 0; m_last_l = 1'b1; exp_fd = '0; exp_ld = '0;
                end else begin
                    case (phase)
                        0: if (fwin || lwin) begin
                            m_owner_l = lwin;
                            m_we      = lwin && l_we;
                            m_addr    = lwin ? l_addr : f_addr;
                            m_be      = l_be;
                            m_wdata   = l_wdata;
                            for (int i = 0; i < BW; i++) m_rdata[8*i +: 8] = ref_mem[16'(m_addr + 16'(i))];
                            if (m_we)
                                for (int i = 0; i < BW; i++)
                                    if (m_be[i]) ref_mem[16'(m_addr + 16'(i))] = m_wdata[8*i +: 8];
                            m_last_l = lwin;
                            phase = 1;
                        end
                        1: phase = 2;
                        2: begin
                            if (m_owner_l) exp_ld = m_we ? '0 : m_rdata;
                            else           exp_fd = m_rdata;
                            phase = 3;
                        end
                        default: phase = 0;
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, hold it until accepted, then let the access complete.
    task automatic req(input bit port_l, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
        bit ok = 1'b0;
        if (port_l) begin
            l_valid = 1'b1; l_we = we; l_addr = a; l_wdata = d; l_be = be;
        end else begin
            f_valid = 1'b1; f_addr = a;
        end
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clk);
            ok = port_l ? l_ready : f_ready;
        end
        check(port_l ? "l_handshake" : "f_handshake", ok, 1'b1);
        tick();
        f_valid = 1'b0;
        l_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0;
        bit ok;
        // Reset held with a pending fetch
        f_valid = 1'b1;
        f_addr  = 16'h0004;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_f_ready", f_ready, 1'b0);
            check("rst_mem_en", mem_en, 1'b0);
            check("rst_rsp_valid", {f_rsp_valid, l_rsp_valid}, 2'b00);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_f_ready", f_ready, 1'b1);
        tick();
        f_valid = 1'b0;
        @(negedge clk);
        check("fetch_mem", {mem_en, mem_we, mem_addr, mem_be}, {1'b1, 1'b0, 16'h0004, 4'hF});
        @(negedge clk);
        @(negedge clk);
        check("fetch_rsp", {f_rsp_valid, l_rsp_valid, f_rsp_data}, {2'b10, 32'h00500093});
        repeat (2) tick();

        // Loader partial write, then fetch it back
        l_valid = 1'b1; l_we = 1'b1; l_addr = 16'h0010; l_wdata = 32'hDEADBEEF; l_be = 4'h3;
        ok = 1'b0;
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clk);
            ok = l_ready;
        end
        check("wr_handshake", ok, 1'b1);
        tick();
        l_valid = 1'b0;
        @(negedge clk);
        check("wr_mem", {mem_en, mem_we, mem_addr, mem_be, mem_wdata},
              {1'b1, 1'b1, 16'h0010, 4'h3, 32'hDEADBEEF});
        @(negedge clk);
        @(negedge clk);
        check("wr_ack", {l_rsp_valid, l_rsp_data}, {1'b1, 32'h0});
        repeat (2) tick();
        req(1'b0, 1'b0, 16'h0010, '0, '0);
        check("wr_fetch_lo", f_rsp_data[15:0], 16'hBEEF);

        // Contention from a fresh reset
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        f_valid = 1'b1; f_addr = 16'h0020;
        l_valid = 1'b1; l_we = 1'b0; l_addr = 16'h0030; l_be = 4'hF;
        s0 = grant_q.size();
        p0 = both_cnt;
        repeat (12) tick();
        f_valid = 1'b0; l_valid = 1'b0;
        check("cont_grants", grant_q.size() - s0, 3);
        if (grant_q.size() >= s0 + 3)
            check("cont_order", {grant_q[s0], grant_q[s0+1], grant_q[s0+2]}, RR ? 3'b010 : 3'b000);
        check("cont_both_ready", both_cnt - p0, 0);
        repeat (4) tick();

        // Reset during WAIT of a fetch abandons it
        f_valid = 1'b1; f_addr = 16'h0008;
        ok = 1'b0;
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clk);
            ok = f_ready;
        end
        check("rstmid_handshake", ok, 1'b1);
        tick();
        f_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        p0 = f_pulses;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("rstmid_no_pulse", f_pulses - p0, 0);
        p0 = f_pulses;
        req(1'b0, 1'b0, 16'h0008, '0, '0);
        check("rstmid_refetch", f_pulses - p0, 1);

        // Randomized traffic, including withdrawn requests and address wrap
        for (int c = 0; c < 600; c++) begin
            tick();
            if (f_acc || (f_valid && $urandom_range(0, 19) == 0)) f_valid = 1'b0;
            if (l_acc || (l_valid && $urandom_range(0, 19) == 0)) l_valid = 1'b0;
            if (!f_valid && $urandom_range(0, 2) == 0) begin
                f_valid = 1'b1;
                f_addr = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                     : 16'($urandom_range(0, 31));
            end
            if (!l_valid && $urandom_range(0, 2) == 0) begin
                l_valid = 1'b1;
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                      : 16'($urandom_range(0, 31));
                l_wdata = $urandom;
                l_be    = 4'($urandom_range(0, 15));
            end
        end
        f_valid = 1'b0; l_valid = 1'b0;
        repeat (6) tick();
        check("both_ready_total", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, byte-addressable instruction memory.
- Port 0 is instruction fetch and is read-only.
- Port 1 is the loader/debug port and can read or write.
- Issues one memory access at a time to a synchronous-read memory (1-cycle read latency) and returns a registered response to the granted requester.

Parameters:
- DATA_WIDTH, 32, data width of memory word and response.
- ADDRESS_WIDTH, 16, byte address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- f_valid  input  1  fetch request valid.
- f_ready  output  1  fetch request accepted this cycle when high with f_valid.
- f_addr  input  ADDRESS_WIDTH  fetch byte address (pc).
- f_rsp_valid  output  1  one-cycle pulse: f_rsp_data valid.
- f_rsp_data  output  DATA_WIDTH  fetched instruction.
- l_valid  input  1  loader request valid.
- l_ready  output  1  loader request accepted.
- l_we  input  1  1 = write, 0 = read.
- l_addr  input  ADDRESS_WIDTH  loader byte address.
- l_wdata  input  DATA_WIDTH  write data.
- l_be  input  DATA_WIDTH/8  byte enables; bit i selects byte at address+i.
- l_rsp_valid  output  1  one-cycle pulse: read data or write acknowledge.
- l_rsp_data  output  DATA_WIDTH  read data; 0 for write acknowledge.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write.
- mem_addr  output  ADDRESS_WIDTH  memory byte address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_be  output  DATA_WIDTH/8  memory byte enables.
- mem_rdata  input  DATA_WIDTH  read data, valid in the cycle after mem_en with mem_we=0.

Behaviour:
- Reset:
  - Synchronous and active-low: on a rising clk edge with rst_n=0, the FSM goes to IDLE.
  - All outputs are held 0 during and after reset: ready, rsp_valid, rsp_data, mem_*.
  - Priority pointer resets to port 0.
  - Reset mid-access abandons the access: no response pulse, no retry.
- FSM states:
  - IDLE:
    - ready is combinational, asserted only to the winner, and only in IDLE.
    - The winner is decided per the priority rule.
    - On handshake (valid & ready), capture addr/we/wdata/be and the owner id, then go to ISSUE.
    - No request: stay in IDLE.
  - ISSUE:
    - mem_en=1 for exactly one cycle, with mem_we/mem_addr/mem_wdata/mem_be from the captured request.
    - Fetch requests force mem_we=0 and mem_be=all ones.
    - Go to WAIT.
  - WAIT:
    - mem_en=0.
    - Read: register mem_rdata into the owner's rsp_data.
    - Write: set l_rsp_data to 0.
    - Go to RESP.
  - RESP:
    - Owner's rsp_valid=1 for exactly one cycle; the other port's rsp_valid stays 0.
    - Go to IDLE.
- Latency: handshake in cycle N, mem_en in N+1, rsp_valid in N+3. Maximum throughput is one access per 4 cycles.
- Data and address:
  - rsp_data holds its value until the next response to the same port.
  - mem_* outputs are driven 0 when mem_en=0.
  - Addresses pass through unmodified: no alignment, no wrap logic.
  - Address wrap at 2**ADDRESS_WIDTH is the memory's responsibility.
- Priority (default, macro absent):
  - Fixed priority, port 0 (fetch) wins when both are valid.
  - Loader can starve while fetch is continuously valid; this is accepted behaviour for the default build.
- Request stability:
  - valid/addr must stay stable until ready; dropping valid before handshake is legal and simply withdraws the request.
  - Requests arriving while not IDLE are ignored until IDLE; they are never queued internally.

Optional Feature:
- Macro IMEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - A 1-bit last-grant register updates on each handshake.
  - When both ports are valid in IDLE, the port not granted last wins.
  - When only one port is valid, that port wins regardless.
  - Register resets to "last = port 1", so fetch wins the first contention.
- When undefined: fixed fetch priority as above; no last-grant register is synthesised.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with f_valid=1 -> f_ready=0, mem_en=0, all rsp_valid=0. Release rst_n -> f_ready=1 in the first IDLE cycle.
- Single fetch: memory word 0x00500093 at addr 0x0004, f_addr=0x0004 -> mem_en=1 with mem_addr=0x0004, mem_we=0, mem_be=0xF at N+1. f_rsp_valid pulse with f_rsp_data=0x00500093 at N+3. l_rsp_valid stays 0.
- Loader write then fetch:
  - Write with l_addr=0x0010, l_wdata=0xDEADBEEF, l_be=0x3 -> mem_we=1, mem_be=0x3 at N+1; l_rsp_valid pulse with l_rsp_data=0 at N+3.
  - Then fetch at 0x0010 -> data byte lanes 0-1 = 0xBEEF.
- Contention, default build: f_valid and l_valid both high continuously for 12 cycles -> three fetch grants and zero loader grants; f_ready and l_ready never high together.
- Contention, IMEM_ARB_ROUND_ROBIN_EN defined: same stimulus -> grants alternate fetch, loader, fetch; first grant is fetch.
- Reset mid-operation: assert rst_n=0 in the WAIT cycle of a fetch -> no f_rsp_valid pulse afterward. After release, a new fetch completes with the normal N+3 latency.
